// File: rtl/crc32_stream_engine_pkg.sv
// Shared constants, FSM state encoding and the byte-serial reflected CRC-32 step
// used by the streaming CRC engine and its lane-fold datapath.
package crc32_stream_engine_pkg;

    localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;

    typedef logic [0:0] fsm_state_t;
    localparam fsm_state_t ST_IDLE     = 1'b0;
    localparam fsm_state_t ST_IN_FRAME = 1'b1;

    // One wire byte, LSB first, through the reflected LFSR.
    function automatic logic [31:0] crc32_byte_update(input logic [31:0] crc,
                                                      input logic [7:0]  data);
        logic [31:0] c;
        c = crc ^ {24'd0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/crc32_stream_engine_if.sv
// Beat stream and result handshake of the CRC engine; master = datapath side, slave = engine.
interface crc32_stream_engine_if #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16
);
    localparam int KEEP_WIDTH = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] i_data;
    logic [KEEP_WIDTH-1:0] i_keep;
    logic                  i_valid;
    logic                  i_last;
    logic                  o_ready;
    logic [31:0]           o_crc;
    logic                  o_crc_valid;
    logic                  i_crc_ready;
    logic                  o_fcs_ok;
    logic [LEN_WIDTH-1:0]  o_frame_len;

    modport master (
        output i_data, i_keep, i_valid, i_last, i_crc_ready,
        input  o_ready, o_crc, o_crc_valid, o_fcs_ok, o_frame_len
    );

    modport slave (
        input  i_data, i_keep, i_valid, i_last, i_crc_ready,
        output o_ready, o_crc, o_crc_valid, o_fcs_ok, o_frame_len
    );

endinterface

// File: rtl/crc32_stream_engine_lane_fold.sv
// Combinational keep-masked CRC-32 update over LANES byte lanes (lane 0 first),
// also returning how many lanes were consumed.
module crc32_lane_fold
    import crc32_stream_engine_pkg::*;
#(
    parameter  int LANES = 4,
    localparam int CNT_W = $clog2(LANES + 1)
) (
    input  logic [31:0]        crc_i,
    input  logic [8*LANES-1:0] data_i,
    input  logic [LANES-1:0]   keep_i,
    output logic [31:0]        crc_o,
    output logic [CNT_W-1:0]   count_o
);

    logic [31:0]      crc_d;
    logic [CNT_W-1:0] cnt_d;

    // NOTE: blocking assignments chain lane after lane within one evaluation;
    // defaults first so every path assigns and no latch is inferred.
    always_comb begin
        crc_d = crc_i;
        cnt_d = '0;
        for (int l = 0; l < LANES; l++) begin
            if (keep_i[l]) begin
                crc_d = crc32_byte_update(crc_d, data_i[8*l +: 8]);
                cnt_d = cnt_d + CNT_W'(1);
            end
        end
    end

    assign crc_o   = crc_d;
    assign count_o = cnt_d;

endmodule

// File: rtl/crc32_stream_engine.sv
// Streaming Ethernet CRC-32 engine: running state, frame length, FCS residue check, result handshake.
// Optional macro CRC32_STREAM_PIPE_EN registers the lower-half lane fold (latency 2, one bubble per frame).
module crc32_stream_engine
    import crc32_stream_engine_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16
) (
    input logic                  clk,
    input logic                  i_reset_n,
    crc32_stream_engine_if.slave bus_io
);

    localparam int KEEP_WIDTH = DATA_WIDTH / 8;
    localparam int CNT_W      = $clog2(KEEP_WIDTH + 1);

    logic [31:0]           crc_q;
    fsm_state_t            state_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic                  res_valid_q;
    logic [31:0]           res_crc_q;
    logic                  res_fcs_ok_q;
    logic [LEN_WIDTH-1:0]  res_len_q;

    logic                  ready;
    logic                  accept;
    logic                  bubble;
    logic [KEEP_WIDTH-1:0] keep_eff;
    logic                  fold_en;
    logic                  fold_last;
    logic [31:0]           fold_crc;
    logic [CNT_W-1:0]      fold_cnt;
    logic [LEN_WIDTH:0]    len_sum;
    logic [LEN_WIDTH-1:0]  len_sat;

    assign accept   = bus_io.i_valid && ready;
    assign keep_eff = bus_io.i_last ? bus_io.i_keep : '1;

`ifdef CRC32_STREAM_PIPE_EN
    localparam int HALF_W = KEEP_WIDTH / 2;
    localparam int HCNT_W = $clog2(HALF_W + 1);

    logic [31:0]         lo_crc, hi_crc, lo_crc_q, state_in;
    logic [HCNT_W-1:0]   lo_cnt, hi_cnt, lo_cnt_q;
    logic [8*HALF_W-1:0] hi_data_q;
    logic [HALF_W-1:0]   hi_keep_q;
    logic                pipe_valid_q, pipe_last_q;

    // The lower half of a beat starts from the state the previous beat completes this cycle.
    assign state_in = (pipe_valid_q && !pipe_last_q) ? hi_crc : crc_q;

    crc32_lane_fold #(.LANES(HALF_W)) u_fold_lo (
        .crc_i   (state_in),
        .data_i  (bus_io.i_data[8*HALF_W-1:0]),
        .keep_i  (keep_eff[HALF_W-1:0]),
        .crc_o   (lo_crc),
        .count_o (lo_cnt)
    );

    crc32_lane_fold #(.LANES(HALF_W)) u_fold_hi (
        .crc_i   (lo_crc_q),
        .data_i  (hi_data_q),
        .keep_i  (hi_keep_q),
        .crc_o   (hi_crc),
        .count_o (hi_cnt)
    );

    always_ff @(posedge clk) begin
        if (!i_reset_n) begin
            pipe_valid_q <= 1'b0;
            pipe_last_q  <= 1'b0;
        end else begin
            pipe_valid_q <= accept;
            pipe_last_q  <= accept && bus_io.i_last;
        end
    end

    // NOTE: payload registers carry no reset; pipe_valid_q alone qualifies them.
    always_ff @(posedge clk) begin
        if (accept) begin
            lo_crc_q  <= lo_crc;
            lo_cnt_q  <= lo_cnt;
            hi_data_q <= bus_io.i_data[DATA_WIDTH-1:8*HALF_W];
            hi_keep_q <= keep_eff[KEEP_WIDTH-1:HALF_W];
        end
    end

    assign bubble    = pipe_last_q;
    assign fold_en   = pipe_valid_q;
    assign fold_last = pipe_last_q;
    assign fold_crc  = hi_crc;
    assign fold_cnt  = CNT_W'(lo_cnt_q) + CNT_W'(hi_cnt);
`else
    crc32_lane_fold #(.LANES(KEEP_WIDTH)) u_fold (
        .crc_i   (crc_q),
        .data_i  (bus_io.i_data),
        .keep_i  (keep_eff),
        .crc_o   (fold_crc),
        .count_o (fold_cnt)
    );

    assign bubble    = 1'b0;
    assign fold_en   = accept;
    assign fold_last = bus_io.i_last;
`endif

    assign len_sum = {1'b0, len_q} + (LEN_WIDTH + 1)'(fold_cnt);
    assign len_sat = len_sum[LEN_WIDTH] ? '1 : len_sum[LEN_WIDTH-1:0];
    assign ready   = !(res_valid_q && !bus_io.i_crc_ready) && !bubble;

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!i_reset_n) begin
            crc_q        <= CRC_INIT;
            state_q      <= ST_IDLE;
            len_q        <= '0;
            res_valid_q  <= 1'b0;
            res_crc_q    <= '0;
            res_fcs_ok_q <= 1'b0;
            res_len_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: if (accept && !bus_io.i_last) state_q <= ST_IN_FRAME;
                default: if (accept && bus_io.i_last)  state_q <= ST_IDLE;
            endcase

            if (fold_en) begin
                crc_q <= fold_last ? CRC_INIT : fold_crc;
                len_q <= fold_last ? '0 : len_sat;
            end

            // A new result wins over consumption so back-to-back frames keep valid high.
            if (fold_en && fold_last) begin
                res_valid_q  <= 1'b1;
                res_crc_q    <= ~fold_crc;
                res_fcs_ok_q <= (fold_crc == CRC_RESIDUE);
                res_len_q    <= len_sat;
            end else if (bus_io.i_crc_ready) begin
                res_valid_q  <= 1'b0;
            end
        end
    end

    assign bus_io.o_ready     = ready;
    assign bus_io.o_crc       = res_crc_q;
    assign bus_io.o_crc_valid = res_valid_q;
    assign bus_io.o_fcs_ok    = res_fcs_ok_q;
    assign bus_io.o_frame_len = res_len_q;

endmodule

// File: tb/tb_crc32_stream_engine.sv
// Self-checking bench: directed 32-bit vectors, then randomized 64-bit frames against a
// table-driven CRC model and a result scoreboard.
`timescale 1ns/1ps
module tb_crc32_stream_engine;

    typedef logic [7:0] byte_q_t [$];
    typedef struct {
        logic [31:0] crc;
        logic        ok;
        logic [15:0] len;
    } exp_t;

`ifdef CRC32_STREAM_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam int LEN64_W = 11;
    localparam int ALL     = 1 << 20;

    logic        clk = 1'b0;
    logic        i_reset_n;
    logic        sel;
    logic [63:0] drv_data;
    logic [7:0]  drv_keep;
    logic        drv_valid, drv_last, crc_ready;
    logic        gaps_en, rand_on;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc   = 0;

    logic [31:0] crc_tab [256];
    exp_t        exp_q [$];
    int          lat_q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    crc32_stream_engine_if #(.DATA_WIDTH(32), .LEN_WIDTH(16))      if32 ();
    crc32_stream_engine_if #(.DATA_WIDTH(64), .LEN_WIDTH(LEN64_W)) if64 ();

    crc32_stream_engine #(.DATA_WIDTH(32), .LEN_WIDTH(16)) u_dut32 (
        .clk(clk), .i_reset_n(i_reset_n), .bus_io(if32)
    );
    crc32_stream_engine #(.DATA_WIDTH(64), .LEN_WIDTH(LEN64_W)) u_dut64 (
        .clk(clk), .i_reset_n(i_reset_n), .bus_io(if64)
    );

    assign if32.i_data      = drv_data[31:0];
    assign if32.i_keep      = drv_keep[3:0];
    assign if32.i_valid     = drv_valid && !sel;
    assign if32.i_last      = drv_last;
    assign if32.i_crc_ready = crc_ready;
    assign if64.i_data      = drv_data;
    assign if64.i_keep      = drv_keep;
    assign if64.i_valid     = drv_valid && sel;
    assign if64.i_last      = drv_last;
    assign if64.i_crc_ready = crc_ready;

    logic        cur_ready, cur_valid, cur_ok;
    logic [31:0] cur_crc;
    logic [15:0] cur_len;
    assign cur_ready = sel ? if64.o_ready     : if32.o_ready;
    assign cur_valid = sel ? if64.o_crc_valid : if32.o_crc_valid;
    assign cur_ok    = sel ? if64.o_fcs_ok    : if32.o_fcs_ok;
    assign cur_crc   = sel ? if64.o_crc       : if32.o_crc;
    assign cur_len   = sel ? 16'(if64.o_frame_len) : if32.o_frame_len;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            logic [31:0] c;
            c = 32'(i);
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            crc_tab[i] = c;
        end
    end

    // Running CRC register after a whole byte sequence (no final inversion).
    function automatic logic [31:0] model_state(input byte_q_t q);
        logic [31:0] s;
        s = 32'hFFFFFFFF;
        foreach (q[i]) s = crc_tab[s[7:0] ^ q[i]] ^ (s >> 8);
        return s;
    endfunction

    function automatic byte_q_t str_bytes(input string s);
        byte_q_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    function automatic byte_q_t rand_bytes(input int n);
        byte_q_t q;
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    // Result latency, scoreboard on each consumed result, and last-beat acceptance tracking.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (lat_q.size() != 0 && lat_q[0] == cyc) begin
            check("latency_valid", cur_valid, 1'b1);
            void'(lat_q.pop_front());
        end
        if (i_reset_n && cur_valid && crc_ready) begin
            check("result_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("sb_crc", cur_crc, e.crc);
                check("sb_fcs_ok", cur_ok, e.ok);
                check("sb_len", cur_len, e.len);
            end
        end
        if (i_reset_n && drv_valid && drv_last && cur_ready) lat_q.push_back(cyc + LAT);
    end

    // Sends a frame on the selected DUT; max_beats below the frame's beat count aborts it unfinished.
    task automatic send_frame(input byte_q_t q, input int max_beats);
        int   w, n, nb, idx, guard, maxlen;
        bit   rdy, last, trunc;
        exp_t e;
        logic [31:0] s;
        w      = sel ? 8 : 4;
        maxlen = sel ? (1 << LEN64_W) - 1 : 65535;
        n      = q.size();
        nb     = (n == 0) ? 1 : (n + w - 1) / w;
        trunc  = (max_beats < nb);
        if (trunc) begin
            nb = max_beats;
        end else begin
            s     = model_state(q);
            e.crc = ~s;
            e.ok  = (s == 32'hDEBB20E3);
            e.len = 16'((n > maxlen) ? maxlen : n);
            exp_q.push_back(e);
        end
        for (int b = 0; b < nb; b++) begin
            if (gaps_en && $urandom_range(0, 3) == 0) begin
                drv_valid = 1'b0;
                @(posedge clk); #1;
            end
            last     = !trunc && (b == nb - 1);
            drv_data = {$urandom, $urandom};
            drv_keep = last ? 8'h00 : 8'($urandom);
            for (int l = 0; l < w; l++) begin
                idx = b * w + l;
                if (idx < n) begin
                    drv_data[8*l +: 8] = q[idx];
                    if (last) drv_keep[l] = 1'b1;
                end
            end
            drv_last  = last;
            drv_valid = 1'b1;
            guard     = 0;
            do begin
                @(negedge clk);
                rdy = cur_ready;
                @(posedge clk); #1;
                guard++;
            end while (!rdy && guard < 2000);
            if (!rdy) begin
                check("accept_timeout", rdy, 1'b1);
                break;
            end
        end
        drv_valid = 1'b0;
        drv_last  = 1'b0;
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while ((exp_q.size() != 0 || lat_q.size() != 0) && g < 5000) begin
            @(negedge clk);
            g++;
        end
        check("drain", exp_q.size() + lat_q.size(), 0);
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
    endtask

    task automatic do_reset(input int n);
        i_reset_n = 1'b0;
        repeat (n) @(posedge clk);
        #1 i_reset_n = 1'b1;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        byte_q_t q;
        logic [31:0] s;
        int k;
        sel = 1'b0; drv_data = '0; drv_keep = '0; drv_valid = 1'b0; drv_last = 1'b0;
        crc_ready = 1'b1; gaps_en = 1'b0; rand_on = 1'b0; i_reset_n = 1'b0;

        do_reset(3);
        @(negedge clk);
        check("rst_crc_valid", cur_valid, 1'b0);
        check("rst_crc", cur_crc, 32'h0);
        check("rst_fcs_ok", cur_ok, 1'b0);
        check("rst_len", cur_len, 16'd0);
        check("rst_ready", cur_ready, 1'b1);
        @(posedge clk); #1;

        send_frame(str_bytes("123456789"), ALL);
        wait_idle();
        check("check_crc", cur_crc, 32'hCBF43926);
        check("check_len", cur_len, 16'd9);
        check("check_fcs_ok", cur_ok, 1'b0);

        q = str_bytes("123456789");
        q.push_back(8'h26); q.push_back(8'h39); q.push_back(8'hF4); q.push_back(8'hCB);
        send_frame(q, ALL);
        wait_idle();
        check("fcs_ok", cur_ok, 1'b1);
        check("fcs_len", cur_len, 16'd13);
        check("fcs_crc", cur_crc, 32'h2144DF1C);

        q = '{8'h00, 8'h00, 8'h00, 8'h00};
        send_frame(q, ALL);
        wait_idle();
        check("zero4_crc", cur_crc, 32'h2144DF1C);

        send_frame(str_bytes("a"), ALL);
        wait_idle();
        check("a_crc", cur_crc, 32'hE8B7BE43);
        check("a_len", cur_len, 16'd1);

        q.delete();
        send_frame(q, ALL);
        wait_idle();
        check("empty_crc", cur_crc, 32'h0);
        check("empty_len", cur_len, 16'd0);

        // Result held unconsumed while the next frame waits.
        crc_ready = 1'b0;
        send_frame(str_bytes("123456789"), ALL);
        k = 0;
        while (!cur_valid && k < 10) begin
            @(negedge clk);
            k++;
        end
        fork
            send_frame(str_bytes("abcdef"), ALL);
            begin
                repeat (5) begin
                    @(negedge clk);
                    check("stall_ready", cur_ready, 1'b0);
                    check("stall_valid", cur_valid, 1'b1);
                    check("stall_crc", cur_crc, 32'hCBF43926);
                    check("stall_len", cur_len, 16'd9);
                end
                @(posedge clk); #1;
                crc_ready = 1'b1;
            end
        join
        wait_idle();

        for (int f = 0; f < 4; f++) send_frame(rand_bytes(4), ALL);
        wait_idle();

        send_frame(rand_bytes(12), 2);
        do_reset(1);
        @(negedge clk);
        check("midrst_crc", cur_crc, 32'h0);
        check("midrst_valid", cur_valid, 1'b0);
        check("midrst_ready", cur_ready, 1'b1);
        @(posedge clk); #1;
        send_frame(str_bytes("123456789"), ALL);
        wait_idle();
        check("after_rst_crc", cur_crc, 32'hCBF43926);

        sel     = 1'b1;
        gaps_en = 1'b1;
        rand_on = 1'b1;
        fork
            while (rand_on) begin
                @(posedge clk); #1;
                crc_ready = ($urandom_range(0, 3) != 0);
            end
        join_none
        for (int f = 0; f < 50; f++) begin
            q = rand_bytes($urandom_range(4, 1500));
            if (f % 4 == 0) begin
                s = ~model_state(q);
                for (int b = 0; b < 4; b++) q.push_back(s[8*b +: 8]);
            end
            send_frame(q, ALL);
        end
        rand_on = 1'b0;
        repeat (3) @(posedge clk);
        #1 crc_ready = 1'b1;
        wait_idle();

        gaps_en = 1'b0;
        send_frame(rand_bytes(2100), ALL);
        wait_idle();
        check("sat_len", cur_len, 16'd2047);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
